// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and grant helper for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam logic [4:0] BYTEMODE_WORD = 5'b01111;

    // MEM wins unless it already took the last two grants and a fetch is waiting.
    function automatic owner_t pick_owner(input logic if_req, input logic mem_req, input logic fair);
        if (mem_req && !(fair && if_req)) begin
            return OWN_MEM;
        end
        return OWN_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline-side and MMU-side signals of the memory port arbiter
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [4:0]  mem_bytemode;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_req;
    logic        mmu_read;
    logic        mmu_write;
    logic [31:0] mmu_addr;
    logic [31:0] mmu_wdata;
    logic [4:0]  mmu_bytemode;
    logic [31:0] mmu_rdata;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_bytemode, mmu_rdata,
        output if_rdata, if_ack, mem_rdata, mem_ack, stall_req,
               mmu_read, mmu_write, mmu_addr, mmu_wdata, mmu_bytemode
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_bytemode, mmu_rdata,
        input  if_rdata, if_ack, mem_rdata, mem_ack, stall_req,
               mmu_read, mmu_write, mmu_addr, mmu_wdata, mmu_bytemode
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the single MMU port between fetch and load/store
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t      state_q,        state_d;
    logic [3:0]  cnt_q,          cnt_d;
    logic        last_mem_q,     last_mem_d;
    logic        fair_q,         fair_d;
    owner_t      owner_q,        owner_d;
    logic        we_q,           we_d;
    logic        mmu_read_q,     mmu_read_d;
    logic        mmu_write_q,    mmu_write_d;
    logic [31:0] mmu_addr_q,     mmu_addr_d;
    logic [31:0] mmu_wdata_q,    mmu_wdata_d;
    logic [4:0]  mmu_bytemode_q, mmu_bytemode_d;
    logic [31:0] if_rdata_q,     if_rdata_d;
    logic [31:0] mem_rdata_q,    mem_rdata_d;
    logic        if_ack_q,       if_ack_d;
    logic        mem_ack_q,      mem_ack_d;
    owner_t      grant;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_mem_d     = last_mem_q;
        fair_d         = fair_q;
        owner_d        = owner_q;
        we_d           = we_q;
        mmu_read_d     = mmu_read_q;
        mmu_write_d    = mmu_write_q;
        mmu_addr_d     = mmu_addr_q;
        mmu_wdata_d    = mmu_wdata_q;
        mmu_bytemode_d = mmu_bytemode_q;
        if_rdata_d     = if_rdata_q;
        mem_rdata_d    = mem_rdata_q;
        if_ack_d       = 1'b0;
        mem_ack_d      = 1'b0;
        grant          = pick_owner(bus.if_req, bus.mem_req, fair_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.if_req || bus.mem_req) begin
                    state_d = ST_ACCESS;
                    cnt_d   = 4'd0;
                    owner_d = grant;
                    if (grant == OWN_MEM) begin
                        we_d           = bus.mem_we;
                        mmu_addr_d     = bus.mem_addr;
                        mmu_wdata_d    = bus.mem_wdata;
                        mmu_bytemode_d = bus.mem_bytemode;
                        mmu_read_d     = ~bus.mem_we;
                        mmu_write_d    = bus.mem_we;
                        fair_d         = last_mem_q;
                        last_mem_d     = 1'b1;
                    end else begin
                        we_d           = 1'b0;
                        mmu_addr_d     = bus.if_addr;
                        mmu_wdata_d    = 32'd0;
                        mmu_bytemode_d = BYTEMODE_WORD;
                        mmu_read_d     = 1'b1;
                        mmu_write_d    = 1'b0;
                        fair_d         = 1'b0;
                        last_mem_d     = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d     = ST_RESP;
                    mmu_read_d  = 1'b0;
                    mmu_write_d = 1'b0;
                    if (owner_q == OWN_MEM) begin
                        mem_ack_d = 1'b1;
                        if (!we_q) mem_rdata_d = bus.mmu_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mmu_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 4'd0;
            last_mem_q     <= 1'b0;
            fair_q         <= 1'b0;
            owner_q        <= OWN_IF;
            we_q           <= 1'b0;
            mmu_read_q     <= 1'b0;
            mmu_write_q    <= 1'b0;
            mmu_addr_q     <= 32'd0;
            mmu_wdata_q    <= 32'd0;
            mmu_bytemode_q <= 5'd0;
            if_rdata_q     <= 32'd0;
            mem_rdata_q    <= 32'd0;
            if_ack_q       <= 1'b0;
            mem_ack_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_mem_q     <= last_mem_d;
            fair_q         <= fair_d;
            owner_q        <= owner_d;
            we_q           <= we_d;
            mmu_read_q     <= mmu_read_d;
            mmu_write_q    <= mmu_write_d;
            mmu_addr_q     <= mmu_addr_d;
            mmu_wdata_q    <= mmu_wdata_d;
            mmu_bytemode_q <= mmu_bytemode_d;
            if_rdata_q     <= if_rdata_d;
            mem_rdata_q    <= mem_rdata_d;
            if_ack_q       <= if_ack_d;
            mem_ack_q      <= mem_ack_d;
        end
    end

    assign bus.mmu_read     = mmu_read_q;
    assign bus.mmu_write    = mmu_write_q;
    assign bus.mmu_addr     = mmu_addr_q;
    assign bus.mmu_wdata    = mmu_wdata_q;
    assign bus.mmu_bytemode = mmu_bytemode_q;
    assign bus.if_rdata     = if_rdata_q;
    assign bus.mem_rdata    = mem_rdata_q;
    assign bus.if_ack       = if_ack_q;
    assign bus.mem_ack      = mem_ack_q;
    // Stall drops in the ack cycle so the pipeline can advance on the same edge.
    assign bus.stall_req    = (bus.if_req & ~if_ack_q) | (bus.mem_req & ~mem_ack_q);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares the single MMU memory port between instruction fetch (IF) and the load/store stage (MEM). Latches one request, drives the MMU read/write strobes for a fixed number of cycles, captures read data and returns a one-cycle acknowledge. Raises a pipeline stall while any request is outstanding. Sits between the CPU pipeline and the MMU.

## Interface
- WAIT_CYCLES, 1: extra cycles an access holds the MMU strobes (access length = WAIT_CYCLES+1, range 0..15)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level, held until if_ack
- if_addr  in  32  fetch address (word access, bytemode 5'b01111)
- if_rdata  out  32  fetched word, valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse
- mem_req  in  1  load/store request, level, held until mem_ack
- mem_we  in  1  1=store, 0=load
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_bytemode  in  5  MMU byte-lane/sign code, passed through unchanged
- mem_rdata  out  32  load result, valid while mem_ack=1
- mem_ack  out  1  one-cycle completion pulse
- stall_req  out  1  pipeline stall
- mmu_read, mmu_write  out  1 each  MMU strobes
- mmu_addr, mmu_wdata  out  32 each  MMU address / write data
- mmu_bytemode  out  5  MMU byte mode
- mmu_rdata  in  32  MMU read data

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: no request -> stay. Otherwise grant, latch addr/wdata/bytemode/we/owner, clear counter, -> ACCESS.
- Grant rule: MEM over IF, except when the previous two grants were both MEM and if_req=1 -> IF granted. Fairness flag cleared by any IF grant.
- ACCESS: mmu_read = ~we, mmu_write = we, mmu_* from latches; counter increments each cycle; at counter==WAIT_CYCLES, mmu_rdata captured into owner's rdata register (loads/fetches only), -> RESP.
- RESP: owner's ack=1 for exactly one cycle, strobes low, -> IDLE. No grant in RESP.
- Non-owner rdata registers keep previous value; stores leave mem_rdata unchanged.
- Request dropped during ACCESS: access still completes, ack still pulses (requester ignores it).
- stall_req = (if_req & ~if_ack) | (mem_req & ~mem_ack), combinational.
- Counter 4 bits; never wraps (exits at WAIT_CYCLES).

## Timing
- Reset (async, immediate): state IDLE, counter 0, fairness flag 0, if_ack=mem_ack=0, mmu_read=mmu_write=0, mmu_addr/mmu_wdata=0, mmu_bytemode=0, if_rdata=mem_rdata=0. Reset mid-ACCESS drops strobes in the same instant; no ack issued.
- Latency: request seen in IDLE at edge E -> ACCESS cycles E+1..E+1+WAIT_CYCLES -> ack in cycle E+2+WAIT_CYCLES. WAIT_CYCLES=1: ack 3 cycles after request.
- Throughput: one access per WAIT_CYCLES+3 cycles.
- mmu_* outputs registered/stable for the entire ACCESS window; MMU samples during low clock phase.
- Simultaneous if_req and mem_req in IDLE: MEM first unless fairness flag forces IF; loser waits, stall_req stays high.

## Structure
- Shared package: state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), owner encoding (OWN_IF=0, OWN_MEM=1), BYTEMODE_WORD=5'b01111.
- Single module, no sub-module; counter and grant logic inline.

## Test plan
- Fetch only, WAIT_CYCLES=1, if_addr=0x80000000, mmu_rdata=0x3C1D8040 -> mmu_read high 2 cycles, if_ack in cycle 3, if_rdata=0x3C1D8040.
- Simultaneous if_req and mem_req (load 0x80400010, bytemode 5'b00001) -> MEM served first, mem_rdata=mmu_rdata, then IF served; stall_req high until if_ack.
- mem_req held continuously with if_req -> grants MEM, MEM, IF, MEM, MEM, IF.
- Store to 0xBFD00400, wdata=0x0000A5A5 -> mmu_write high WAIT_CYCLES+1 cycles, mmu_read=0, mem_ack pulses once, mem_rdata unchanged.
- rst_n low during ACCESS -> strobes and acks 0 immediately, state IDLE; first request after release granted normally.
- WAIT_CYCLES=0 -> one ACCESS cycle, ack 2 cycles after request.
